// File: rtl/morra_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : morra_pkg
//  Purpose  : Shared types and defaults for the Morra Cinese scoreboard.
//             Holds the 2-bit round/match result code, the scoreboard state
//             enumeration and the default FIFO depth and counter width.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package morra_pkg;

   // Round / match result code, shared by MANCHE, PARTITA and the FIFO.
   typedef enum logic [1:0] {
      NONE = 2'b00,
      P1   = 2'b01,
      P2   = 2'b10,
      DRAW = 2'b11
   } result_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PLAYING = 2'd1,
      DONE    = 2'd2
   } sb_state_t;

   localparam int DEFAULT_DEPTH = 8;
   localparam int DEFAULT_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/morra_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module   : morra_scoreboard_if
//  Purpose  : Valid/ready handshake carrying the round-history FIFO head
//             from the scoreboard to a display or host reader.
//  Ports    : HIST_VALID - FIFO not empty (scoreboard -> reader)
//             HIST_DATA  - oldest buffered MANCHE code (scoreboard -> reader)
//             HIST_READY - reader accepts HIST_DATA (reader -> scoreboard)
//  Revision : 1.0 - initial release
// ============================================================================
interface morra_scoreboard_if;

   logic       HIST_VALID;
   logic [1:0] HIST_DATA;
   logic       HIST_READY;

   modport master (
      output HIST_VALID,
      output HIST_DATA,
      input  HIST_READY
   );

   modport slave (
      input  HIST_VALID,
      input  HIST_DATA,
      output HIST_READY
   );

endinterface
`default_nettype wire

// File: rtl/morra_hist_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : morra_hist_fifo
//  Purpose  : Synchronous first-word-fall-through FIFO of 2-bit round codes.
//  Ports    : clk, rst_n       - clock, async active-low reset
//             flush            - empties the FIFO, overrides push/pop
//             push, din        - write request and data
//             pop              - read request (ignored while empty)
//             dout             - head entry, NONE when empty
//             full, empty      - occupancy flags
//  Revision : 1.0 - initial release
// ============================================================================
module morra_hist_fifo
   import morra_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       push,
   input  logic       pop,
   input  logic [1:0] din,
   output logic [1:0] dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [1:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;

   logic w_pop;
   logic w_push;

   assign full   = (r_count == (AW+1)'(DEPTH));
   assign empty  = (r_count == '0);
   assign w_pop  = pop && !empty;
   // A push into a full FIFO is accepted only when a pop frees the slot
   // in the same cycle; the write lands where the read pointer leaves.
   assign w_push = push && (!full || w_pop);
   assign dout   = empty ? NONE : r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: the pointers/count define what is valid.
   always_ff @(posedge clk) begin
      if (w_push && !flush) r_mem[r_wr_ptr] <= din;
   end

endmodule
`default_nettype wire

// File: rtl/morra_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : morra_scoreboard
//  Purpose  : Tallies Morra Cinese rounds from the game FSMD, latches the
//             final match result and buffers per-round history in a FIFO.
//  Ports    : clk, rst_n                 - clock, async active-low reset
//             INIZIO                     - match restart strobe
//             MANCHE, PARTITA            - round / match result from game
//             WINS_P1, WINS_P2, DRAWS,
//             ROUNDS                     - saturating tallies
//             MATCH_DONE, MATCH_RESULT   - latched match outcome
//             HIST_OVF                   - sticky history overflow
//             hist                       - history valid/ready handshake
//  Revision : 1.0 - initial release
// ============================================================================
module morra_scoreboard
   import morra_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             INIZIO,
   input  logic [1:0]       MANCHE,
   input  logic [1:0]       PARTITA,
   output logic [CNT_W-1:0] WINS_P1,
   output logic [CNT_W-1:0] WINS_P2,
   output logic [CNT_W-1:0] DRAWS,
   output logic [CNT_W-1:0] ROUNDS,
   output logic             MATCH_DONE,
   output logic [1:0]       MATCH_RESULT,
   output logic             HIST_OVF,
   morra_scoreboard_if.master hist
);

   localparam logic [1:0]       ST_IDLE    = IDLE;
   localparam logic [1:0]       ST_PLAYING = PLAYING;
   localparam logic [1:0]       ST_DONE    = DONE;
   localparam logic [CNT_W-1:0] C_MAX      = '1;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_wins_p1;
   logic [CNT_W-1:0] r_wins_p2;
   logic [CNT_W-1:0] r_draws;
   logic [CNT_W-1:0] r_rounds;
   logic             r_done;
   logic [1:0]       r_result;
   logic             r_ovf;

   logic       w_round;
   logic       w_pop;
   logic       w_full;
   logic       w_empty;
   logic [1:0] w_head;

   // INIZIO suppresses both the round event and the pop of its cycle.
   assign w_round = (r_state == ST_PLAYING) && !INIZIO && (MANCHE != NONE);
   assign w_pop   = !w_empty && hist.HIST_READY && !INIZIO;

   morra_hist_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (INIZIO),
      .push  (w_round),
      .pop   (w_pop),
      .din   (MANCHE),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_wins_p1 <= '0;
         r_wins_p2 <= '0;
         r_draws   <= '0;
         r_rounds  <= '0;
         r_done    <= 1'b0;
         r_result  <= NONE;
         r_ovf     <= 1'b0;
      end else if (INIZIO) begin
         r_state   <= ST_PLAYING;
         r_wins_p1 <= '0;
         r_wins_p2 <= '0;
         r_draws   <= '0;
         r_rounds  <= '0;
         r_done    <= 1'b0;
         r_result  <= NONE;
         r_ovf     <= 1'b0;
      end else if (r_state == ST_PLAYING) begin
         if (w_round) begin
            if (r_rounds != C_MAX) r_rounds <= r_rounds + CNT_W'(1);
            case (MANCHE)
               P1:      if (r_wins_p1 != C_MAX) r_wins_p1 <= r_wins_p1 + CNT_W'(1);
               P2:      if (r_wins_p2 != C_MAX) r_wins_p2 <= r_wins_p2 + CNT_W'(1);
               DRAW:    if (r_draws   != C_MAX) r_draws   <= r_draws   + CNT_W'(1);
               default: ;
            endcase
            // Dropped only if full and no pop makes room this cycle.
            if (w_full && !w_pop) r_ovf <= 1'b1;
         end
         if (PARTITA != NONE) begin
            r_result <= PARTITA;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
         end
      end
   end

   assign WINS_P1         = r_wins_p1;
   assign WINS_P2         = r_wins_p2;
   assign DRAWS           = r_draws;
   assign ROUNDS          = r_rounds;
   assign MATCH_DONE      = r_done;
   assign MATCH_RESULT    = r_result;
   assign HIST_OVF        = r_ovf;
   assign hist.HIST_VALID = !w_empty;
   assign hist.HIST_DATA  = w_head;

endmodule
`default_nettype wire

// File: tb/tb_morra_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_morra_scoreboard
//  Purpose  : Self-checking bench for morra_scoreboard using directed
//             scenarios and randomized traffic against a queue-based model.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_morra_scoreboard;

   localparam int DEPTH = 8;
   localparam int CNT_W = 4;
   localparam int MAXC  = 15;

   logic             clk     = 1'b0;
   logic             rst_n   = 1'b0;
   logic             INIZIO  = 1'b0;
   logic [1:0]       MANCHE  = 2'b00;
   logic [1:0]       PARTITA = 2'b00;
   logic [CNT_W-1:0] WINS_P1, WINS_P2, DRAWS, ROUNDS;
   logic             MATCH_DONE;
   logic [1:0]       MATCH_RESULT;
   logic             HIST_OVF;

   morra_scoreboard_if hist ();

   morra_scoreboard #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .INIZIO       (INIZIO),
      .MANCHE       (MANCHE),
      .PARTITA      (PARTITA),
      .WINS_P1      (WINS_P1),
      .WINS_P2      (WINS_P2),
      .DRAWS        (DRAWS),
      .ROUNDS       (ROUNDS),
      .MATCH_DONE   (MATCH_DONE),
      .MATCH_RESULT (MATCH_RESULT),
      .HIST_OVF     (HIST_OVF),
      .hist         (hist)
   );

   always #5 clk = ~clk;

   wire [22:0] dut_vec = {WINS_P1, WINS_P2, DRAWS, ROUNDS, MATCH_DONE, MATCH_RESULT,
                          hist.HIST_VALID, hist.HIST_DATA, HIST_OVF};

   int n_checks = 0;
   int n_pass   = 0;

   // ---------------- reference model ----------------
   int         m_w1, m_w2, m_dr, m_rn;
   bit         m_play, m_done, m_ovf;
   logic [1:0] m_res;
   logic [1:0] m_q[$];

   function automatic int sat(input int v);
      return (v < MAXC) ? v + 1 : v;
   endfunction

   task automatic model_reset();
      m_w1 = 0; m_w2 = 0; m_dr = 0; m_rn = 0;
      m_play = 0; m_done = 0; m_ovf = 0; m_res = 2'b00;
      m_q.delete();
   endtask

   task automatic model_clk(input logic ini, input logic [1:0] m, input logic [1:0] p,
                            input logic rdy);
      bit popped;
      popped = (m_q.size() > 0) && rdy;
      if (ini) begin
         model_reset();
         m_play = 1;
         return;
      end
      if (popped) void'(m_q.pop_front());
      if (m_play) begin
         if (m != 2'b00) begin
            m_rn = sat(m_rn);
            if (m == 2'b01) m_w1 = sat(m_w1);
            if (m == 2'b10) m_w2 = sat(m_w2);
            if (m == 2'b11) m_dr = sat(m_dr);
            if (m_q.size() < DEPTH) m_q.push_back(m);
            else m_ovf = 1;
         end
         if (p != 2'b00) begin
            m_done = 1;
            m_res  = p;
            m_play = 0;
         end
      end
   endtask

   function automatic logic [22:0] exp_vec();
      logic [1:0] head;
      head = (m_q.size() > 0) ? m_q[0] : 2'b00;
      return {4'(m_w1), 4'(m_w2), 4'(m_dr), 4'(m_rn), m_done, m_res,
              (m_q.size() > 0), head, m_ovf};
   endfunction

   // One clock: drive at negedge, model at posedge, sample 1 unit later.
   task automatic cycle(input logic ini, input logic [1:0] m, input logic [1:0] p,
                        input logic rdy);
      @(negedge clk);
      INIZIO = ini; MANCHE = m; PARTITA = p; hist.HIST_READY = rdy;
      @(posedge clk);
      model_clk(ini, m, p, rdy);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      hist.HIST_READY = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if (dut_vec !== 23'd0) $display("FAIL reset_state: got %h want %h", dut_vec, 23'd0);
      else n_pass++;
      rst_n = 1'b1;
      cycle(0, 2'b01, 2'b01, 0);   // IDLE ignores round and match inputs
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL idle_ignore: got %h want %h", dut_vec, exp_vec());
      else n_pass++;
   endtask

   task automatic test_basic_rounds();
      logic [1:0] seq[4] = '{2'b01, 2'b10, 2'b11, 2'b01};
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         cycle(0, seq[i], 0, 0);
         n_checks++;
         if (dut_vec !== exp_vec()) $display("FAIL basic_round%0d: got %h want %h", i, dut_vec, exp_vec());
         else n_pass++;
      end
      n_checks++;
      if ({WINS_P1, WINS_P2, DRAWS, ROUNDS, MATCH_DONE} !== {4'd2, 4'd1, 4'd1, 4'd4, 1'b0})
         $display("FAIL basic_tally: got %h want %h", {WINS_P1, WINS_P2, DRAWS, ROUNDS, MATCH_DONE},
                  {4'd2, 4'd1, 4'd1, 4'd4, 1'b0});
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (hist.HIST_DATA !== seq[i] || hist.HIST_VALID !== 1'b1)
            $display("FAIL basic_drain%0d: got %b/%b want 1/%b", i, hist.HIST_VALID, hist.HIST_DATA, seq[i]);
         else n_pass++;
         cycle(0, 0, 0, 1);
      end
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL basic_empty: got %h want %h", dut_vec, exp_vec());
      else n_pass++;
   endtask

   task automatic test_match_end();
      cycle(0, 2'b10, 2'b10, 0);
      n_checks++;
      if (dut_vec !== exp_vec() || MATCH_DONE !== 1'b1 || MATCH_RESULT !== 2'b10)
         $display("FAIL match_end: got %h want %h", dut_vec, exp_vec());
      else n_pass++;
      cycle(0, 2'b01, 2'b01, 0);
      n_checks++;
      if (dut_vec !== exp_vec() || WINS_P1 !== 4'd2 || MATCH_RESULT !== 2'b10)
         $display("FAIL done_ignore: got %h want %h", dut_vec, exp_vec());
      else n_pass++;
      cycle(0, 0, 0, 1);           // FIFO still drainable in DONE
      n_checks++;
      if (dut_vec !== exp_vec()) $display("FAIL done_drain: got %h want %h", dut_vec, exp_vec());
      else n_pass++;
   endtask

   task automatic test_overflow();
      logic [1:0] codes[9];
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 9; i++) begin
         codes[i] = 2'($urandom_range(1, 3));
         cycle(0, codes[i], 0, 0);
         n_checks++;
         if (dut_vec !== exp_vec()) $display("FAIL ovf_push%0d: got %h want %h", i, dut_vec, exp_vec());
         else n_pass++;
      end
      n_checks++;
      if (HIST_OVF !== 1'b1 || ROUNDS !== 4'd9)
         $display("FAIL ovf_flag: got ovf=%b rounds=%0d want ovf=1 rounds=9", HIST_OVF, ROUNDS);
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (hist.HIST_VALID !== 1'b1 || hist.HIST_DATA !== codes[i])
            $display("FAIL ovf_drain%0d: got %b/%b want 1/%b", i, hist.HIST_VALID, hist.HIST_DATA, codes[i]);
         else n_pass++;
         cycle(0, 0, 0, 1);
      end
      n_checks++;
      if (hist.HIST_VALID !== 1'b0) $display("FAIL ovf_empty: got %b want 0", hist.HIST_VALID);
      else n_pass++;
   endtask

   task automatic test_full_push_pop();
      int         cnt;
      logic [1:0] last;
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 8; i++) cycle(0, 2'($urandom_range(1, 3)), 0, 0);
      cycle(0, 2'b11, 0, 1);
      n_checks++;
      if (dut_vec !== exp_vec() || HIST_OVF !== 1'b0)
         $display("FAIL full_pushpop: got %h want %h", dut_vec, exp_vec());
      else n_pass++;
      cnt  = 0;
      last = 2'b00;
      for (int k = 0; k < 20 && hist.HIST_VALID === 1'b1; k++) begin
         last = hist.HIST_DATA;
         cnt++;
         cycle(0, 0, 0, 1);
      end
      n_checks++;
      if (cnt != 8 || last !== 2'b11)
         $display("FAIL full_drain: got count=%0d last=%b want count=8 last=11", cnt, last);
      else n_pass++;
   endtask

   task automatic test_saturation();
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 16; i++) cycle(0, 2'b01, 0, 1);
      n_checks++;
      if (WINS_P1 !== 4'd15 || ROUNDS !== 4'd15 || dut_vec !== exp_vec())
         $display("FAIL saturate: got %h want %h", dut_vec, exp_vec());
      else n_pass++;
      cycle(1, 0, 0, 0);
      n_checks++;
      if (dut_vec !== 23'd0) $display("FAIL restart_clear: got %h want %h", dut_vec, 23'd0);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      cycle(1, 0, 0, 0);
      cycle(0, 2'b01, 0, 0);
      cycle(0, 2'b10, 0, 0);
      cycle(0, 2'b11, 0, 0);
      #2;                          // between edges
      rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (dut_vec !== 23'd0) $display("FAIL async_reset: got %h want %h", dut_vec, 23'd0);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle(0, 2'b01, 0, 0);
         n_checks++;
         if (dut_vec !== 23'd0) $display("FAIL post_reset_idle%0d: got %h want %h", i, dut_vec, 23'd0);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      logic       ini, rdy;
      logic [1:0] m, p;
      for (int i = 0; i < 400; i++) begin
         ini = ($urandom_range(0, 39) == 0);
         m   = 2'($urandom_range(0, 3));
         p   = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         rdy = ($urandom_range(0, 2) == 0);
         cycle(ini, m, p, rdy);
         n_checks++;
         if (dut_vec !== exp_vec()) $display("FAIL random_cyc%0d: got %h want %h", i, dut_vec, exp_vec());
         else n_pass++;
      end
   endtask

   initial begin
      hist.HIST_READY = 1'b0;
      test_reset();
      test_basic_rounds();
      test_match_end();
      test_overflow();
      test_full_push_pop();
      test_saturation();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
